// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Purpose  : Oversampling UART receiver. The serial line is idle high and
//            frames are 8N1, sent LSB first. Each bit is sampled once, at
//            its centre. The received byte is held in a one-entry buffer
//            that the consumer drains with a valid/ready handshake.
// Options  : Define UART_RX_PARITY_EN to receive 8E1 frames instead. An even
//            parity bit then follows the data bits and is checked.
// Ports    : clk            system clock, rising edge
//            rstn           asynchronous active-low reset
//            rx_i           asynchronous serial input (synchronised inside)
//            data_ready_i   consumer accepts data_out_o while data_valid_o=1
//            data_out_o     last accepted byte
//            data_valid_o   data_out_o holds an unconsumed byte
//            frame_err_o    1-cycle pulse: stop bit sampled low
//            parity_err_o   1-cycle pulse: parity mismatch (0 without option)
//            overrun_o      1-cycle pulse: good frame dropped, buffer full
//            rx_busy_o      receiver is not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_receiver #(
  parameter int CLOCKS_PER_PULSE = 5208
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_i,
  input  logic       data_ready_i,
  output logic [7:0] data_out_o,
  output logic       data_valid_o,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o,
  output logic       rx_busy_o
);

  localparam int               CNT_W  = $clog2(CLOCKS_PER_PULSE);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    RX_PARITY = 3'd3,
`endif
    RX_STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             rx_meta_q, rx_s_q;
  logic             good_frame;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
  logic             perr_q, perr_d;
`endif

  // Two-flop synchroniser. Both flops reset to the idle level so that
  // releasing reset cannot look like a start edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    data_d     = data_q;
    // A handshake drains the buffer. A good frame that completes in the same
    // cycle refills it below.
    valid_d    = valid_q & ~data_ready_i;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;
    good_frame = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    perr_d     = 1'b0;
`endif

    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = RX_START;
          idx_d   = '0;
        end
      end
      RX_START: begin
        // Recheck the line at mid start bit. This rejects short glitches and
        // puts every later sample at the centre of its bit.
        if (cnt_q == C_HALF) begin
          cnt_d   = '0;
          state_d = rx_s_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == C_FULL) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rx_s_q;
          idx_d          = idx_q + 1'b1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (cnt_q == C_FULL) begin
          cnt_d   = '0;
          par_d   = rx_s_q;
          state_d = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        // Going idle at mid stop bit leaves half a bit of margin to catch a
        // start bit that follows with no gap.
        if (cnt_q == C_FULL) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (!rx_s_q) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (^{shreg_q, par_q}) begin
            perr_d = 1'b1;
`endif
          end else begin
            good_frame = 1'b1;
          end
        end
      end
      default: begin
        state_d = RX_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    if (good_frame) begin
      if (!valid_q || data_ready_i) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign data_out_o   = data_q;
  assign data_valid_o = valid_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = ovr_q;
  assign rx_busy_o    = (state_q != RX_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule
`default_nettype wire
